spi_slave: RTL and testbench

//  Byte-oriented SPI target (slave) front end for the serial-flash model.

---
 rtl/spi_slave.sv | 111 +++++++++++
 tb/tb_spi_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target front end: oversamples SCK/CS_n/MOSI in the i_Clk domain, strobes each
// received byte and serialises the byte held for the next slot, MSB first.
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte
);

    localparam logic [1:0] MODE = SPI_MODE[1:0];
    localparam logic       CPOL = MODE[1];
    localparam logic       CPHA = MODE[0];

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       miso_q, miso_d;

    logic sck_edge_s, lead_s, trail_s, sample_s, shift_s, cs_fall_s, load_s;

    // sck_q[2] is the previous synced level, so an edge is a difference between [1] and [2]
    assign sck_edge_s = ~cs_q[1] & (sck_q[1] ^ sck_q[2]);
    assign lead_s     = sck_edge_s & (sck_q[2] == CPOL);
    assign trail_s    = sck_edge_s & (sck_q[2] != CPOL);
    assign sample_s   = CPHA ? trail_s : lead_s;
    assign shift_s    = CPHA ? lead_s : trail_s;
    assign cs_fall_s  = ~cs_q[1] & cs_q[2];
    // A shift edge seen with the bit count at zero is the start of a new byte slot
    assign load_s     = ((CPHA == 1'b0) & cs_fall_s) | (shift_s & (bit_cnt_q == 3'd0));

    // Next-state logic for the receive and transmit shifters
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        tx_hold_d  = i_TX_DV ? i_TX_Byte : tx_hold_q;
        tx_shift_d = tx_shift_q;
        miso_d     = 1'b1;
        if (cs_q[1]) begin
            bit_cnt_d = 3'd0;
        end else begin
            if (sample_s) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_d = rx_shift_d;
                    rx_dv_d   = 1'b1;
                    bit_cnt_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end else begin
                rx_shift_d = rx_shift_q;
            end
            if (load_s) begin
                tx_shift_d = tx_hold_d;
            end else if (shift_s) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end else begin
                tx_shift_d = tx_shift_q;
            end
            miso_d = tx_shift_d[7];
        end
    end

    // Synchronisers and state registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sck_q      <= {3{CPOL}};
            cs_q       <= 3'b111;
            mosi_q     <= 2'b00;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_dv_q    <= 1'b0;
            tx_hold_q  <= 8'hFF;
            tx_shift_q <= 8'hFF;
            miso_q     <= 1'b1;
        end else begin
            sck_q      <= {sck_q[1:0], i_SPI_Clk};
            cs_q       <= {cs_q[1:0], i_SPI_CS_n};
            mosi_q     <= {mosi_q[0], i_SPI_MOSI};
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
        end
    end

    assign o_SPI_MISO = miso_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-banged master per instance,
// a strobe scoreboard and a byte-level model of the transmit holding register.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sck;
    logic [3:0] cs_n;
    logic       mosi;
    logic [3:0] pre_dv;
    logic [7:0] pre_byte;
    logic [3:0] resp_dv = 4'b0000;
    logic [7:0] resp_byte = 8'h00;
    logic [3:0] miso;
    logic [3:0] rx_dv;
    logic [7:0] rx_byte [4];

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q [$];
    logic [7:0] resp_q [$];
    logic [7:0] hold_m [4];
    logic [7:0] last_rx [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g)) u_dut (
            .i_Clk      (clk),
            .i_Rst      (rst),
            .i_SPI_Clk  (sck[g]),
            .i_SPI_CS_n (cs_n[g]),
            .i_SPI_MOSI (mosi),
            .o_SPI_MISO (miso[g]),
            .o_RX_DV    (rx_dv[g]),
            .o_RX_Byte  (rx_byte[g]),
            .i_TX_DV    (pre_dv[g] | resp_dv[g]),
            .i_TX_Byte  (resp_dv[g] ? resp_byte : pre_byte)
        );
    end

    // Scoreboard: every strobe must match the oldest expected {mode, byte}
    always @(negedge clk) begin
        logic [9:0] e;
        for (int m = 0; m < 4; m++) begin
            if (!rst && rx_dv[m]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_strobe: unexpected strobe mode%0d byte=%02h", m, rx_byte[m]);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {m[1:0], rx_byte[m]}) begin
                        failures++;
                        $display("FAIL rx_byte: got mode%0d byte=%02h expected mode%0d byte=%02h",
                                 m, rx_byte[m], e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    // Command-FSM stand-in: answers a strobe with the next queued byte
    always @(negedge clk) begin
        resp_dv = 4'b0000;
        for (int m = 0; m < 4; m++) begin
            if (!rst && rx_dv[m] && resp_q.size() > 0) begin
                resp_byte  = resp_q.pop_front();
                resp_dv[m] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        half();
    endtask

    task automatic cs_high(input int m);
        half();
        cs_n[m] = 1'b1;
        half();
    endtask

    task automatic preload(input int m, input logic [7:0] b);
        pre_byte  = b;
        pre_dv[m] = 1'b1;
        @(negedge clk);
        pre_dv[m] = 1'b0;
        hold_m[m] = b;
    endtask

    // Master: drives nbits of b MSB first and returns the bits read from MISO
    task automatic xfer(input int m, input logic [7:0] b, input int nbits, output logic [7:0] got);
        logic cpol;
        logic cpha;
        cpol = m[1];
        cpha = m[0];
        got  = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = b[i];
                half();
                sck[m] = ~cpol;
                got = {got[6:0], miso[m]};
                half();
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi = b[i];
                half();
                sck[m] = cpol;
                got = {got[6:0], miso[m]};
                half();
            end
        end
    endtask

    // Full byte: MISO must carry the holding value current at the byte start
    task automatic xfer_chk(input int m, input logic [7:0] b, input bit do_resp, input logic [7:0] rb);
        logic [7:0] got;
        logic [7:0] exp_miso;
        exp_miso = hold_m[m];
        exp_q.push_back({m[1:0], b});
        if (do_resp) resp_q.push_back(rb);
        xfer(m, b, 8, got);
        check($sformatf("miso_byte_mode%0d", m), {24'h0, got}, {24'h0, exp_miso});
        last_rx[m] = b;
        if (do_resp) hold_m[m] = rb;
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("%s_rx_dv%0d", tag, m), {31'h0, rx_dv[m]}, 32'h0);
            check($sformatf("%s_rx_byte%0d", tag, m), {24'h0, rx_byte[m]}, 32'h0);
            check($sformatf("%s_miso%0d", tag, m), {31'h0, miso[m]}, 32'h1);
        end
    endtask

    initial begin
        logic [7:0] dummy;
        sck      = 4'b1100;
        cs_n     = 4'b1111;
        mosi     = 1'b0;
        pre_dv   = 4'b0000;
        pre_byte = 8'h00;
        for (int m = 0; m < 4; m++) begin
            hold_m[m]  = 8'hFF;
            last_rx[m] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0 single command byte
        cs_low(0);
        xfer_chk(0, 8'h03, 1'b0, 8'h00);
        cs_high(0);

        // Mode 0 burst; responder loads A5 after byte 4 and 5A after byte 5
        cs_low(0);
        xfer_chk(0, 8'h03, 1'b0, 8'h00);
        xfer_chk(0, 8'h00, 1'b0, 8'h00);
        xfer_chk(0, 8'h00, 1'b0, 8'h00);
        xfer_chk(0, 8'h10, 1'b1, 8'hA5);
        xfer_chk(0, 8'($urandom), 1'b1, 8'h5A);
        xfer_chk(0, 8'($urandom), 1'b0, 8'h00);
        cs_high(0);

        // Partial byte aborted by CS_n, then a clean byte
        cs_low(0);
        xfer(0, 8'($urandom), 5, dummy);
        cs_high(0);
        cs_low(0);
        xfer_chk(0, 8'h60, 1'b0, 8'h00);
        cs_high(0);

        // Asynchronous reset in the middle of a byte
        cs_low(0);
        xfer(0, 8'hB3, 4, dummy);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        for (int m = 0; m < 4; m++) begin
            hold_m[m]  = 8'hFF;
            last_rx[m] = 8'h00;
        end
        cs_high(0);
        cs_low(0);
        xfer_chk(0, 8'h06, 1'b0, 8'h00);
        cs_high(0);

        // SCK activity while deselected must be ignored
        for (int i = 0; i < 16; i++) begin
            mosi   = 1'($urandom);
            sck[0] = ~sck[0];
            half();
            check("miso_idle", {31'h0, miso[0]}, 32'h1);
        end

        // Modes 1..3: preloaded 3C out, C7 in
        for (int m = 1; m < 4; m++) begin
            preload(m, 8'h3C);
            cs_low(m);
            xfer_chk(m, 8'hC7, 1'b0, 8'h00);
            cs_high(m);
        end

        // Randomised transactions in every mode
        for (int m = 0; m < 4; m++) begin
            for (int t = 0; t < 3; t++) begin
                if ($urandom_range(0, 1) == 1) preload(m, 8'($urandom));
                cs_low(m);
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                    xfer_chk(m, 8'($urandom), 1'($urandom), 8'($urandom));
                end
                cs_high(m);
            end
        end

        repeat (20) @(negedge clk);
        check("strobes_outstanding", exp_q.size(), 32'h0);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("rx_byte_hold%0d", m), {24'h0, rx_byte[m]}, {24'h0, last_rx[m]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
